// File: rtl/gprmc_encoder.sv
// Streams one NMEA $GPRMC sentence built from snapshotted fix fields over a valid/ready byte link.
// Define GPRMC_ENC_CHECKSUM_EN to append "*HH" before CR LF (47 bytes); otherwise 44 bytes.
module gprmc_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic        fix_valid,
  input  logic [63:0] lat,
  input  logic        lat_s,
  input  logic [63:0] lon,
  input  logic        lon_w,
  input  logic [47:0] spd,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    BODY,
`ifdef GPRMC_ENC_CHECKSUM_EN
    STAR,
    CS_HI,
    CS_LO,
`endif
    CR,
    LF
  } state_t;

  localparam logic [5:0] LAST_IDX = 6'd41;

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic        start;
  logic        accept;
  logic        fix_q, lat_s_q, lon_w_q;
  logic [63:0] lat_q, lon_q;
  logic [47:0] spd_q;
`ifdef GPRMC_ENC_CHECKSUM_EN
  logic [7:0]  cs;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Body byte at index i; field characters are taken first-char-at-MSB.
  function automatic logic [7:0] body_char(input logic [5:0] i);
    logic [5:0] k;
    k = 6'd0;
    body_char = 8'h2C;
    if (i >= 6'd10 && i <= 6'd17) begin
      k = 6'd17 - i;
      body_char = 8'(lat_q >> {k, 3'b000});
    end else if (i >= 6'd21 && i <= 6'd28) begin
      k = 6'd28 - i;
      body_char = 8'(lon_q >> {k, 3'b000});
    end else if (i >= 6'd32 && i <= 6'd37) begin
      k = 6'd37 - i;
      body_char = 8'(spd_q >> {k, 3'b000});
    end else begin
      case (i)
        6'd0:    body_char = "$";
        6'd1:    body_char = "G";
        6'd2:    body_char = "P";
        6'd3:    body_char = "R";
        6'd4:    body_char = "M";
        6'd5:    body_char = "C";
        6'd8:    body_char = fix_q ? "A" : "V";
        6'd19:   body_char = lat_s_q ? "S" : "N";
        6'd30:   body_char = lon_w_q ? "W" : "E";
        default: body_char = 8'h2C;
      endcase
    end
  endfunction

  assign start    = send && (state == IDLE);
  assign tx_valid = (state != IDLE);
  assign busy     = tx_valid;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (start) begin
      fix_q   <= fix_valid;
      lat_q   <= lat;
      lat_s_q <= lat_s;
      lon_q   <= lon;
      lon_w_q <= lon_w;
      spd_q   <= spd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 6'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == LF) && accept;
      if (start)
        idx <= 6'd0;
      else if (state == BODY && accept)
        idx <= idx + 6'd1;
    end
  end

`ifdef GPRMC_ENC_CHECKSUM_EN
  // The leading '$' (index 0) is excluded from the XOR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cs <= 8'h00;
    else if (start)
      cs <= 8'h00;
    else if (state == BODY && accept && idx != 6'd0)
      cs <= cs ^ tx_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (send) state_nxt = BODY;
`ifdef GPRMC_ENC_CHECKSUM_EN
      BODY:  if (accept && idx == LAST_IDX) state_nxt = STAR;
      STAR:  if (accept) state_nxt = CS_HI;
      CS_HI: if (accept) state_nxt = CS_LO;
      CS_LO: if (accept) state_nxt = CR;
`else
      BODY:  if (accept && idx == LAST_IDX) state_nxt = CR;
`endif
      CR:    if (accept) state_nxt = LF;
      LF:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    case (state)
      BODY:  tx_data = body_char(idx);
`ifdef GPRMC_ENC_CHECKSUM_EN
      STAR:  tx_data = "*";
      CS_HI: tx_data = hex_char(cs[7:4]);
      CS_LO: tx_data = hex_char(cs[3:0]);
`endif
      CR:    tx_data = 8'h0D;
      LF:    tx_data = 8'h0A;
      default: tx_data = 8'h00;
    endcase
  end

endmodule

// File: doc/gprmc_encoder.md
# gprmc_encoder

Builds a complete NMEA `$GPRMC` sentence from fix status, latitude, longitude and speed, and streams it byte by byte to the UART transmitter through a valid/ready handshake. It is the transmit-side counterpart of the `$GPRMC` parser. Its field layout is what the parser consumes: status in field 2, latitude in field 3, longitude in field 5, speed in field 7. It is used for loopback test and for re-broadcasting a fix.

## Interface
- No parameters. Sentence layout is fixed.
- `clk` input 1: single clock domain.
- `rst_n` input 1: reset. Asynchronous assert, active-low.
- `send` input 1: request one sentence. Sampled only when `busy`=0.
- `fix_valid` input 1: 1 emits `A`, 0 emits `V`.
- `lat` input 64: 8 ASCII chars. `lat[63:56]` is the first char.
- `lat_s` input 1: 0 emits `N`, 1 emits `S`.
- `lon` input 64: 8 ASCII chars. `lon[63:56]` is the first char.
- `lon_w` input 1: 0 emits `E`, 1 emits `W`.
- `spd` input 48: 6 ASCII chars. `spd[47:40]` is the first char.
- `tx_data` output 8: byte to the UART TX.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: the UART TX accepts the byte in any cycle where `tx_valid && tx_ready`.
- `busy` output 1: a sentence is in progress.
- `done` output 1: one-cycle pulse after the final byte is accepted.

## Operation
- Sentence bytes (checksum enabled, 47 bytes), in order:
  - `$GPRMC`
  - `,`, then an empty time field, then `,`
  - status char, then `,`
  - 8 latitude chars, then `,`
  - N/S, then `,`
  - 8 longitude chars, then `,`
  - E/W, then `,`
  - 6 speed chars
  - `,,,,` (course, date, magvar and magvar-direction fields are empty)
  - `*`, checksum high hex digit, checksum low hex digit
  - CR (0x0D), LF (0x0A)
- Field characters are emitted verbatim. No validation is performed.
- Snapshot: all field inputs are registered on the edge where `send && !busy`. Input changes after that point do not affect the sentence in flight.
- A `send` pulse while `busy`=1 is ignored. It is not queued.
- Checksum:
  - 8-bit XOR of every byte strictly between `$` and `*`.
  - Accumulated as each byte is accepted.
  - Cleared on snapshot.
- Hex digits are uppercase ASCII: nibble 0–9 maps to 0x30+n, nibble A–F maps to 0x37+n.
- State machine:
  - IDLE → on `send`, go to BODY.
  - BODY (byte index 0..41) → after `,` index 41 is accepted, go to STAR.
  - STAR → CS_HI → CS_LO → CR → LF → IDLE.
  - Each transition happens only on handshake acceptance.
- Registered 6-bit byte index. Character selection is a mux from the index and the snapshot registers.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=8'h00, `busy`=0, `done`=0. State is IDLE, checksum is 0, index is 0.
- `send` accepted at edge N:
  - `busy`=1 and `tx_valid`=1 with `tx_data`=`$` from cycle N+1.
- Holding rule: while `tx_valid && !tx_ready`, `tx_data` and `tx_valid` are held stable.
- After acceptance at edge K, the next byte is presented at cycle K+1. There are no bubbles.
- With `tx_ready` held high, `tx_valid` is high for exactly 47 consecutive cycles.
- On the edge that accepts LF:
  - `tx_valid`→0, `busy`→0, `done`→1 for exactly one cycle.
- Back-to-back: `send` asserted during the `done` cycle is accepted. The next `$` appears the following cycle.
- `rst_n` low mid-sentence immediately forces all reset values. No partial sentence resumes; the next sentence requires a new `send`.
- `tx_ready` high while `tx_valid`=0 has no effect.

## Configuration
- `GPRMC_ENC_CHECKSUM_EN` defined:
  - STAR/CS_HI/CS_LO are present.
  - Sentence is 47 bytes, ending `*HH` CR LF.
- `GPRMC_ENC_CHECKSUM_EN` undefined:
  - The checksum XOR logic and the STAR/CS_HI/CS_LO states are removed.
  - BODY goes directly to CR after the last `,`.
  - Sentence is 44 bytes, ending `,,,,` CR LF.
  - All other timing rules are unchanged.

## Test plan
- Golden sentence, checksum on, `tx_ready`=1:
  - Stimulus: `fix_valid`=1, `lat`="4124.812", `lat_s`=0, `lon`="08151.68", `lon_w`=1, `spd`="000.50", one `send` pulse.
  - Expected: bytes exactly `$GPRMC,,A,4124.812,N,08151.68,W,000.50,,,,*2F` CR LF. `tx_valid` high for 47 cycles. `done` pulses once on the cycle after LF is accepted.
- Backpressure:
  - Stimulus: same inputs; `tx_ready` toggles pseudo-randomly, including 10-cycle low stretches.
  - Expected: identical byte sequence. `tx_data` is stable whenever `tx_valid && !tx_ready`. No byte is dropped or duplicated.
- Snapshot and ignored send:
  - Stimulus: change `fix_valid` to 0 and `lat` to "9999.999" at byte 3; pulse `send` at bytes 5 and 20.
  - Expected: the sentence still carries `A`, "4124.812" and `*2F`. Exactly one sentence is sent and one `done` pulse occurs.
- Back-to-back:
  - Stimulus: `send` asserted in the `done` cycle.
  - Expected: second `$` presented the next cycle. `busy` is low for only the `done` cycle.
- Reset mid-sentence:
  - Stimulus: `rst_n` low during byte 20, then released.
  - Expected: `tx_valid`=0, `busy`=0, `done`=0 immediately. No output until the next `send`. The next sentence is complete and its checksum is correct.
- Macro off:
  - Stimulus: rebuild without `GPRMC_ENC_CHECKSUM_EN` and apply the golden stimulus.
  - Expected: 44 bytes ending `,000.50,,,,` CR LF, with no `*`.
